// File: rtl/gray_rx_checker_pkg.sv
// Shared definitions for the Gray-code receive checker.
//   - Default data and wrap-counter widths.
//   - FSM state encodings. These stay as fixed 2-bit constants so that
//     legacy code comparing raw state values keeps working.
package gray_rx_checker_pkg;

  localparam int unsigned GRAY_W_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 8;

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_LOCKED   = 2'd1;
  localparam logic [1:0] ST_ERROR    = 2'd2;

endpackage

// File: rtl/gray_to_bin.sv
// Purely combinational Gray-to-binary converter.
// Ports:
//   i_gray  in  W  Gray-coded value
//   o_bin   out W  binary equivalent
// Bit i of the result is the XOR of all Gray bits at or above i. This is
// the same as bin[W-1]=g[W-1], bin[i]=bin[i+1]^g[i], written without a
// self-referencing loop.
module gray_to_bin
  import gray_rx_checker_pkg::*;
#(
  parameter int unsigned W = GRAY_W_DEF
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_rx_checker.sv
// Receive-side Gray-code decoder and link monitor.
// Samples GrayIn on each enabled cycle and decodes it to binary. It checks
// that each sample either holds the previous value or advances it by +1 mod
// 2^W with a single-bit change. It also counts wrap-arounds and flags
// protocol errors.
// Ports:
//   Clk        in   1      rising-edge clock
//   Reset      in   1      synchronous, active-high, highest priority
//   En         in   1      sample enable; 0 freezes all state
//   GrayIn     in   W      Gray-coded input
//   BinOut     out  W      binary of the last accepted sample
//   BinValid   out  1      strobe: BinOut updated by an accepted sample
//   Overflow   out  1      strobe: accepted step from 2^W-1 to 0
//   WrapCount  out  CNT_W  number of Overflow events since reset
//   Locked     out  1      FSM in LOCKED
//   Error      out  1      FSM in ERROR
// Build option GRAY_RX_RESYNC_EN:
//   When defined, the first enabled sample in ERROR is accepted exactly as
//   in UNLOCKED. WrapCount is preserved.
//   When undefined, ERROR is left only by Reset.
module gray_rx_checker
  import gray_rx_checker_pkg::*;
#(
  parameter int unsigned W     = GRAY_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [W-1:0]     GrayIn,
  output logic [W-1:0]     BinOut,
  output logic             BinValid,
  output logic             Overflow,
  output logic [CNT_W-1:0] WrapCount,
  output logic             Locked,
  output logic             Error
);

  logic [1:0]       r_state;
  logic [W-1:0]     r_prev_gray;
  logic [W-1:0]     r_prev_bin;
  logic [W-1:0]     r_bin_out;
  logic             r_bin_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_wrap_count;

  logic [W-1:0]     w_bin;
  logic [W-1:0]     w_prev_bin_inc;
  logic             w_hold;
  logic             w_step_ok;
  logic             w_prev_max;

  gray_to_bin #(.W(W)) u_gray_to_bin (
    .i_gray (GrayIn),
    .o_bin  (w_bin)
  );

  assign w_prev_bin_inc = r_prev_bin + 1'b1;
  assign w_hold         = (GrayIn == r_prev_gray);
  // Require both a single-bit change and a +1 step. A one-bit change can
  // still step backward, so the popcount alone is not sufficient.
  assign w_step_ok      = ($countones(GrayIn ^ r_prev_gray) == 1) &&
                          (w_bin == w_prev_bin_inc);
  assign w_prev_max     = &r_prev_bin;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_UNLOCKED;
      r_prev_gray  <= '0;
      r_prev_bin   <= '0;
      r_bin_out    <= '0;
      r_bin_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      r_bin_valid <= 1'b0;
      r_overflow  <= 1'b0;
      if (En) begin
        case (r_state)
          ST_UNLOCKED: begin
            r_bin_out   <= w_bin;
            r_prev_gray <= GrayIn;
            r_prev_bin  <= w_bin;
            r_bin_valid <= 1'b1;
            r_state     <= ST_LOCKED;
          end
          ST_LOCKED: begin
            if (w_hold) begin
              r_bin_valid <= 1'b1;
            end else if (w_step_ok) begin
              r_bin_out   <= w_bin;
              r_prev_gray <= GrayIn;
              r_prev_bin  <= w_bin;
              r_bin_valid <= 1'b1;
              if (w_prev_max) begin
                r_overflow   <= 1'b1;
                r_wrap_count <= r_wrap_count + 1'b1;
              end
            end else begin
              // BinOut and the prev registers keep the last good sample.
              r_state <= ST_ERROR;
            end
          end
          ST_ERROR: begin
`ifdef GRAY_RX_RESYNC_EN
            r_bin_out   <= w_bin;
            r_prev_gray <= GrayIn;
            r_prev_bin  <= w_bin;
            r_bin_valid <= 1'b1;
            r_state     <= ST_LOCKED;
`endif
          end
          default: begin
            r_state <= ST_UNLOCKED;
          end
        endcase
      end
    end
  end

  assign BinOut    = r_bin_out;
  assign BinValid  = r_bin_valid;
  assign Overflow  = r_overflow;
  assign WrapCount = r_wrap_count;
  assign Locked    = (r_state == ST_LOCKED);
  assign Error     = (r_state == ST_ERROR);

endmodule

// File: tb/tb_gray_rx_checker.sv
// Directed bench for gray_rx_checker (W=3, CNT_W=8). Each stimulus step
// pushes its hand-computed expected outputs into a queue. A separate
// monitor pops one entry per clock and compares it against the DUT.
module tb_gray_rx_checker;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] GrayIn;
  logic [2:0] BinOut;
  logic       BinValid;
  logic       Overflow;
  logic [7:0] WrapCount;
  logic       Locked;
  logic       Error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic [2:0] bin;
    logic       v;
    logic       o;
    logic [7:0] w;
    logic       l;
    logic       e;
  } exp_t;

  exp_t q[$];

  gray_rx_checker #(.W(3), .CNT_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .GrayIn    (GrayIn),
    .BinOut    (BinOut),
    .BinValid  (BinValid),
    .Overflow  (Overflow),
    .WrapCount (WrapCount),
    .Locked    (Locked),
    .Error     (Error)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Monitor: compare each queued expectation 1 ns after its clock edge.
  initial begin
    forever begin
      exp_t x;
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        n_checks++;
        if ({BinOut, BinValid, Overflow, WrapCount, Locked, Error} !==
            {x.bin, x.v, x.o, x.w, x.l, x.e}) begin
          n_fail++;
          $display("FAIL %s: got bin=%0d valid=%b ovf=%b wrap=%0d lock=%b err=%b, expected bin=%0d valid=%b ovf=%b wrap=%0d lock=%b err=%b",
                   x.name, BinOut, BinValid, Overflow, WrapCount, Locked, Error,
                   x.bin, x.v, x.o, x.w, x.l, x.e);
        end
      end
    end
  end

  task automatic step(input string nm, input logic rst, input logic en,
                      input logic [2:0] g, input logic [2:0] eb,
                      input logic ev, input logic eo, input logic [7:0] ew,
                      input logic el, input logic ee);
    exp_t x;
    Reset  = rst;
    En     = en;
    GrayIn = g;
    @(posedge Clk);
    x.name = nm; x.bin = eb; x.v = ev; x.o = eo; x.w = ew; x.l = el; x.e = ee;
    q.push_back(x);
    @(negedge Clk);
  endtask

  initial begin
    Reset  = 1'b1;
    En     = 1'b0;
    GrayIn = 3'b000;
    @(negedge Clk);

    // Full-cycle stream.
    step("t1_rst0", 1, 1, 3'b000, 3'd0, 0, 0, 8'd0, 0, 0);
    step("t1_rst1", 1, 1, 3'b000, 3'd0, 0, 0, 8'd0, 0, 0);
    step("t1_g000", 0, 1, 3'b000, 3'd0, 1, 0, 8'd0, 1, 0);
    step("t1_g001", 0, 1, 3'b001, 3'd1, 1, 0, 8'd0, 1, 0);
    step("t1_g011", 0, 1, 3'b011, 3'd2, 1, 0, 8'd0, 1, 0);
    step("t1_g010", 0, 1, 3'b010, 3'd3, 1, 0, 8'd0, 1, 0);
    step("t1_g110", 0, 1, 3'b110, 3'd4, 1, 0, 8'd0, 1, 0);
    step("t1_g111", 0, 1, 3'b111, 3'd5, 1, 0, 8'd0, 1, 0);
    step("t1_g101", 0, 1, 3'b101, 3'd6, 1, 0, 8'd0, 1, 0);
    step("t1_g100", 0, 1, 3'b100, 3'd7, 1, 0, 8'd0, 1, 0);
    step("t1_wrap", 0, 1, 3'b000, 3'd0, 1, 1, 8'd1, 1, 0);

    // Hold.
    step("t2_g001", 0, 1, 3'b001, 3'd1, 1, 0, 8'd1, 1, 0);
    step("t2_h0",   0, 1, 3'b011, 3'd2, 1, 0, 8'd1, 1, 0);
    step("t2_h1",   0, 1, 3'b011, 3'd2, 1, 0, 8'd1, 1, 0);
    step("t2_h2",   0, 1, 3'b011, 3'd2, 1, 0, 8'd1, 1, 0);

    // Multi-bit jump.
    step("t3_rst",  1, 1, 3'b000, 3'd0, 0, 0, 8'd0, 0, 0);
    step("t3_g001", 0, 1, 3'b001, 3'd1, 1, 0, 8'd0, 1, 0);
    step("t3_jump", 0, 1, 3'b010, 3'd1, 0, 0, 8'd0, 0, 1);

    // Error exit.
`ifdef GRAY_RX_RESYNC_EN
    step("t5_resync", 0, 1, 3'b110, 3'd4, 1, 0, 8'd0, 1, 0);
`else
    step("t5_sticky", 0, 1, 3'b110, 3'd1, 0, 0, 8'd0, 0, 1);
`endif
    step("t5_rst",  1, 1, 3'b110, 3'd0, 0, 0, 8'd0, 0, 0);

    // Backward single-bit step.
    step("t4_g011", 0, 1, 3'b011, 3'd2, 1, 0, 8'd0, 1, 0);
    step("t4_back", 0, 1, 3'b001, 3'd2, 0, 0, 8'd0, 0, 1);
    step("t4_rst",  1, 0, 3'b001, 3'd0, 0, 0, 8'd0, 0, 0);

    // Freeze, then a reset in the middle of the stream.
    step("t6_g000", 0, 1, 3'b000, 3'd0, 1, 0, 8'd0, 1, 0);
    step("t6_g001", 0, 1, 3'b001, 3'd1, 1, 0, 8'd0, 1, 0);
    step("t6_g011", 0, 1, 3'b011, 3'd2, 1, 0, 8'd0, 1, 0);
    for (int i = 0; i < 5; i++)
      step("t6_frz", 0, 0, 3'b110, 3'd2, 0, 0, 8'd0, 1, 0);
    step("t6_g010", 0, 1, 3'b010, 3'd3, 1, 0, 8'd0, 1, 0);
    step("t6_g110", 0, 1, 3'b110, 3'd4, 1, 0, 8'd0, 1, 0);
    step("t6_g111", 0, 1, 3'b111, 3'd5, 1, 0, 8'd0, 1, 0);
    step("t6_rst",  1, 1, 3'b101, 3'd0, 0, 0, 8'd0, 0, 0);
    step("t6_g101", 0, 1, 3'b101, 3'd6, 1, 0, 8'd0, 1, 0);

    // A reset on the wrap edge discards the wrap.
    step("w_g100",  0, 1, 3'b100, 3'd7, 1, 0, 8'd0, 1, 0);
    step("w_rst",   1, 1, 3'b000, 3'd0, 0, 0, 8'd0, 0, 0);

    Reset = 1'b0;
    En    = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge Clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
